// File: rtl/restador_flotante_seq.sv
// Multi-cycle floating-point subtractor, s = a - b.
// The datapath is iterative. It compares the operands, aligns them one bit
// per cycle, adds or subtracts them, and then normalizes one bit per cycle.
// Valid/ready semantics: a request is accepted on a rising edge where start=1
// and the FSM is in IDLE. busy stays high from the next cycle through DONE.
// done pulses for one cycle with s/ovf/unf valid. start is ignored while busy.
module restador_flotante_seq #(
  parameter int unsigned E = 8,
  parameter int unsigned M = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [E+M:0]     a,
  input  logic [E+M:0]     b,
  output logic             busy,
  output logic             done,
  output logic [E+M:0]     s,
  output logic             ovf,
  output logic             unf,
  output logic [2:0]       dbg_state
);

  localparam int unsigned W  = E + M + 1;
  localparam int unsigned MW = M + 3;            // {carry, hidden, fraction, guard}
  localparam int unsigned KW = $clog2(M + 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMP   = 3'd1,
    S_ALIGN = 3'd2,
    S_ARITH = 3'd3,
    S_NORM  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic            sign_q, sign_d;
  logic [E-1:0]    exp_q, exp_d;
  logic [MW-1:0]   big_q, big_d, small_q, small_d;
  logic [KW-1:0]   k_q, k_d;
  logic            eff_sub_q, eff_sub_d;
  logic [W-1:0]    s_q, s_d;
  logic            ovf_q, ovf_d, unf_q, unf_d;

  // Operand decode. A zero exponent means a zero operand, so its fraction is dropped.
  logic [E-1:0]    exp_a, exp_b, exp_l, exp_s, diff;
  logic [M-1:0]    frac_a, frac_b;
  logic [MW-1:0]   mant_a, mant_b, mant_l, mant_s;
  logic [E+M-1:0]  key_a, key_b;
  logic            a_ge_b, far, sign_l;
  logic [E:0]      exp_inc;

  assign exp_a  = a_q[W-2:M];
  assign exp_b  = b_q[W-2:M];
  assign frac_a = (exp_a == '0) ? '0 : a_q[M-1:0];
  assign frac_b = (exp_b == '0) ? '0 : b_q[M-1:0];
  assign mant_a = (exp_a == '0) ? '0 : {2'b01, frac_a, 1'b0};
  assign mant_b = (exp_b == '0) ? '0 : {2'b01, frac_b, 1'b0};
  assign key_a  = {exp_a, frac_a};
  assign key_b  = {exp_b, frac_b};
  assign a_ge_b = (key_a >= key_b);
  assign exp_l  = a_ge_b ? exp_a : exp_b;
  assign exp_s  = a_ge_b ? exp_b : exp_a;
  assign mant_l = a_ge_b ? mant_a : mant_b;
  assign mant_s = a_ge_b ? mant_b : mant_a;
  assign diff   = exp_l - exp_s;
  assign far    = (diff > E'(M + 1));
  // The subtrahend's sign is flipped, so a larger b gives the result ~sign_b.
  assign sign_l = a_ge_b ? a_q[W-1] : ~b_q[W-1];
  assign exp_inc = {1'b0, exp_q} + {{E{1'b0}}, 1'b1};

  // Next-state and datapath updates for the iterative subtractor.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    big_d     = big_q;
    small_d   = small_q;
    k_d       = k_q;
    eff_sub_d = eff_sub_q;
    s_d       = s_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = S_CMP;
        end
      end
      S_CMP: begin
        sign_d    = sign_l;
        exp_d     = exp_l;
        big_d     = mant_l;
        eff_sub_d = (a_q[W-1] != ~b_q[W-1]);
        small_d   = far ? '0 : mant_s;
        k_d       = far ? '0 : diff[KW-1:0];
        state_d   = (!far && diff != '0) ? S_ALIGN : S_ARITH;
      end
      S_ALIGN: begin
        small_d = small_q >> 1;
        k_d     = k_q - KW'(1);
        if (k_q == KW'(1)) state_d = S_ARITH;
      end
      S_ARITH: begin
        big_d   = eff_sub_q ? (big_q - small_q) : (big_q + small_q);
        state_d = S_NORM;
      end
      S_NORM: begin
        if (big_q == '0) begin
          s_d     = '0;
          state_d = S_DONE;
        end else if (big_q[MW-1]) begin
          big_d = big_q >> 1;
          exp_d = exp_inc[E-1:0];
          if (exp_inc >= {1'b0, {E{1'b1}}}) begin
            ovf_d   = 1'b1;
            s_d     = {sign_q, {E{1'b1}}, {M{1'b0}}};
            state_d = S_DONE;
          end
        end else if (!big_q[MW-2]) begin
          big_d = big_q << 1;
          exp_d = exp_q - E'(1);
          if (exp_q <= E'(1)) begin
            unf_d   = 1'b1;
            s_d     = '0;
            state_d = S_DONE;
          end
        end else begin
          s_d     = {sign_q, exp_q, big_q[M:1]};
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers. Reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      big_q     <= '0;
      small_q   <= '0;
      k_q       <= '0;
      eff_sub_q <= 1'b0;
      s_q       <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      big_q     <= big_d;
      small_q   <= small_d;
      k_q       <= k_d;
      eff_sub_q <= eff_sub_d;
      s_q       <= s_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign s         = s_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign dbg_state = state_q;

endmodule
